// File: rtl/core_types_pkg.sv
// Shared widths and types for the dispatch/issue front end.
// The dispatch queue entry layout lives here so the issue side can reuse it.
package core_types_pkg;

  localparam int DQ_ENTRIES         = 8;
  localparam int LOG_DQ_ENTRIES     = $clog2(DQ_ENTRIES);
  localparam int LOG_PR_COUNT       = 7;
  localparam int LOG_ROB_ENTRIES    = 7;
  localparam int DISPATCH_WAY_COUNT = 4;
  localparam int OP_WIDTH           = 4;

  typedef logic [LOG_DQ_ENTRIES-1:0] dq_ptr_t;
  typedef logic [LOG_DQ_ENTRIES:0]   dq_count_t;

  typedef struct packed {
    logic [OP_WIDTH-1:0]        op;
    logic [LOG_PR_COUNT-1:0]    A_PR;
    logic [LOG_PR_COUNT-1:0]    B_PR;
    logic [LOG_PR_COUNT-1:0]    dest_PR;
    logic [LOG_ROB_ENTRIES-1:0] ROB_index;
  } dq_entry_t;

endpackage

// File: rtl/dq_enq_select.sv
// Enqueue selection: acks valid ways in way order while free slots remain and
// gives each way its write offset from the tail.
module dq_enq_select
  import core_types_pkg::*;
#(
  parameter int WAYS = DISPATCH_WAY_COUNT
) (
  input  logic [WAYS-1:0] valid,
  input  dq_count_t       free,
  output logic [WAYS-1:0] ack,
  output dq_ptr_t         offset [WAYS],
  output dq_count_t       ack_count
);

  dq_count_t taken;

  // NOTE: blocking assignments here because 'taken' is a running total that
  // each loop iteration must see updated; every output gets a default first
  // so no latch is inferred.
  always_comb begin
    ack   = '0;
    taken = '0;
    for (int i = 0; i < WAYS; i++) begin
      offset[i] = taken[LOG_DQ_ENTRIES-1:0];
      if (valid[i] && (taken < free)) begin
        ack[i] = 1'b1;
        taken  = taken + dq_count_t'(1);
      end
    end
    ack_count = taken;
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue: up to DISPATCH_WAY_COUNT enqueues per cycle into a
// circular FIFO, oldest op offered to the issue queue, flushed on ROB restart.
module dispatch_queue
  import core_types_pkg::*;
#(
  parameter int DISPATCH_WAY_COUNT = core_types_pkg::DISPATCH_WAY_COUNT
) (
  input  logic                                               CLK,
  input  logic                                               RST,
  input  logic [DISPATCH_WAY_COUNT-1:0]                      dispatch_valid_by_way,
  input  logic [DISPATCH_WAY_COUNT-1:0][OP_WIDTH-1:0]        dispatch_op_by_way,
  input  logic [DISPATCH_WAY_COUNT-1:0][LOG_PR_COUNT-1:0]    dispatch_A_PR_by_way,
  input  logic [DISPATCH_WAY_COUNT-1:0][LOG_PR_COUNT-1:0]    dispatch_B_PR_by_way,
  input  logic [DISPATCH_WAY_COUNT-1:0][LOG_PR_COUNT-1:0]    dispatch_dest_PR_by_way,
  input  logic [DISPATCH_WAY_COUNT-1:0][LOG_ROB_ENTRIES-1:0] dispatch_ROB_index_by_way,
  output logic [DISPATCH_WAY_COUNT-1:0]                      dispatch_ack_by_way,
  output logic                                               iq_valid,
  output logic [OP_WIDTH-1:0]                                iq_op,
  output logic [LOG_PR_COUNT-1:0]                            iq_A_PR,
  output logic [LOG_PR_COUNT-1:0]                            iq_B_PR,
  output logic [LOG_PR_COUNT-1:0]                            iq_dest_PR,
  output logic [LOG_ROB_ENTRIES-1:0]                         iq_ROB_index,
  input  logic                                               iq_ready,
  input  logic                                               restart_valid,
  output dq_count_t                                          dq_count
);

  dq_entry_t entries [DQ_ENTRIES];
  dq_ptr_t   head;
  dq_ptr_t   tail;
  dq_count_t count;

  dq_count_t free;
  dq_count_t ack_count;
  dq_ptr_t   offset    [DISPATCH_WAY_COUNT];
  dq_ptr_t   wr_idx    [DISPATCH_WAY_COUNT];
  dq_entry_t new_entry [DISPATCH_WAY_COUNT];
  dq_entry_t head_entry;
  logic      deq;

  // Restart zeroes the free count, which forces every ack low that cycle.
  assign free     = restart_valid ? '0 : dq_count_t'(DQ_ENTRIES) - count;
  assign iq_valid = (count != '0);
  assign deq      = iq_valid && iq_ready && !restart_valid;
  assign dq_count = count;

  dq_enq_select #(
    .WAYS(DISPATCH_WAY_COUNT)
  ) u_enq_select (
    .valid     (dispatch_valid_by_way),
    .free      (free),
    .ack       (dispatch_ack_by_way),
    .offset    (offset),
    .ack_count (ack_count)
  );

  always_comb begin
    for (int i = 0; i < DISPATCH_WAY_COUNT; i++) begin
      wr_idx[i]    = tail + offset[i];
      new_entry[i] = '{op:        dispatch_op_by_way[i],
                       A_PR:      dispatch_A_PR_by_way[i],
                       B_PR:      dispatch_B_PR_by_way[i],
                       dest_PR:   dispatch_dest_PR_by_way[i],
                       ROB_index: dispatch_ROB_index_by_way[i]};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge CLK) begin
    if (RST || restart_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + ack_count[LOG_DQ_ENTRIES-1:0];
      head  <= head + dq_ptr_t'(deq);
      count <= count + ack_count - dq_count_t'(deq);
    end
  end

  // NOTE: the entry array is deliberately not reset; occupancy is tracked
  // only by head/tail/count, so stale contents are never observed.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DISPATCH_WAY_COUNT; i++) begin
      if (dispatch_ack_by_way[i] && !RST) begin
        entries[wr_idx[i]] <= new_entry[i];
      end
    end
  end

  assign head_entry   = entries[head];
  assign iq_op        = head_entry.op;
  assign iq_A_PR      = head_entry.A_PR;
  assign iq_B_PR      = head_entry.B_PR;
  assign iq_dest_PR   = head_entry.dest_PR;
  assign iq_ROB_index = head_entry.ROB_index;

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

In-order dispatch queue between rename/dispatch and the ALU issue queue. Accepts up to 4 renamed ops per cycle from the dispatch stage, buffers them in a DQ_ENTRIES-deep circular FIFO, and presents the oldest op to the issue queue through a valid/ready handshake. The whole queue is discarded on a ROB restart.

## Interface
Parameters:
- DISPATCH_WAY_COUNT, 4: enqueue ways per cycle.
- DQ_ENTRIES, 8 (package): queue depth, power of two.
- LOG_PR_COUNT, 7; LOG_ROB_ENTRIES, 7 (package): tag widths.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset, synchronous, active-high.
- dispatch_valid_by_way  in  4  way i carries a valid op.
- dispatch_op_by_way  in  4x4  op encoding.
- dispatch_A_PR_by_way, dispatch_B_PR_by_way, dispatch_dest_PR_by_way  in  4x7 each  physical registers.
- dispatch_ROB_index_by_way  in  4x7  ROB tag.
- dispatch_ack_by_way  out  4  combinational; way i accepted this cycle.
- iq_valid  out  1  head entry present.
- iq_op  out  4;  iq_A_PR, iq_B_PR, iq_dest_PR  out  7 each;  iq_ROB_index  out  7: head entry fields.
- iq_ready  in  1  issue queue takes head when iq_valid.
- restart_valid  in  1  flush all entries.
- dq_count  out  LOG_DQ_ENTRIES+1  current occupancy.

## Operation
- State: entry array, head ptr, tail ptr (LOG_DQ_ENTRIES bits, wrap naturally), count register.
- Free slots: free = DQ_ENTRIES - count, from registered count only; a same-cycle dequeue does not free a slot until next cycle.
- Enqueue: scan ways 0..3; the k-th valid way (k counted from 0 among valid ways, in way order) is acked iff k < free. Not all-or-nothing; invalid ways never acked. Acked ways write entry at tail+k; tail += number acked.
- Dequeue: fires when iq_valid && iq_ready; head += 1.
- count_next = count + acked - dequeued.
- iq_valid = (count != 0); iq_* fields read the entry at head.
- Restart: highest priority. In a restart cycle dispatch_ack_by_way forced 0, any dequeue handshake discarded; next cycle head = tail = count = 0.
- Entry contents are not cleared on dequeue/restart; only pointers and count matter.

## Timing
- Reset: head = tail = count = 0; iq_valid = 0, dq_count = 0; dispatch_ack_by_way = valid mask limited to 4 (free = 8); iq_* fields don't-care while iq_valid = 0.
- Enqueue-to-iq_valid latency: 1 cycle (op enqueued in cycle N visible at head in N+1 if queue was empty).
- Throughput: 4 enqueues and 1 dequeue per cycle.
- Full (count = 8): all acks 0, even when dequeue fires same cycle.
- Empty: iq_valid = 0; iq_ready ignored.
- Wrap: pointer arithmetic modulo DQ_ENTRIES; multi-way writes straddling index 7->0 are legal.
- RST and restart_valid together: RST result (identical).

## Structure
- core_types_pkg gains DISPATCH_WAY_COUNT and typedef dq_entry_t (op, A_PR, B_PR, dest_PR, ROB_index); DQ_ENTRIES/LOG_DQ_ENTRIES reused.
- One sub-module is natural: dq_enq_select, purely combinational (valid mask, free -> ack mask and per-way write offsets).

## Test plan
- Reset: assert RST 2 cycles; release with dispatch_valid_by_way = 4'b1111 -> ack 4'b1111, iq_valid = 0 that cycle, dq_count = 4 next cycle.
- Fill: iq_ready = 0, enqueue ROB 0-3 then 4-7 -> dq_count = 8; third cycle valid 4'b1111 -> ack 4'b0000, dq_count stays 8.
- Partial accept: count = 6, valid = 4'b1011 -> ack 4'b0011; ways 0,1 written at tail, tail+1; dq_count = 8.
- Wrap order: head = tail = 6, enqueue ROB 10,11,12,13 -> written at 6,7,0,1; with iq_ready = 1 iq_ROB_index sequence 10,11,12,13 over 4 cycles, then iq_valid = 0.
- Full with dequeue: count = 8, iq_ready = 1, valid = 4'b0001 -> ack 0, dq_count = 7; next cycle same input -> ack 4'b0001, dq_count = 7.
- Restart: count = 5, valid = 4'b1111, iq_ready = 1, restart_valid = 1 -> ack 4'b0000; next cycle dq_count = 0, iq_valid = 0, then enqueue of ROB 20 appears at head 1 cycle later.
